vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive side of the VGA timing interface: samples incoming hsync/vsync (positive
//  polarity, one pixel per clk), regenerates hpos/vpos/display_on aligned to the
//  sync edges, and checks every line and frame against the parameterised timing.
//  Sits between an external/looped-back sync source and pixel capture/checker logic.
// PARAMETERS
//  H_DISPLAY   1024  visible pixels per line
//  H_BACK        80  horizontal back porch
//  H_FRONT       48  horizontal front porch
//  H_SYNC        32  hsync width
//  V_DISPLAY    768  visible lines
//  V_TOP         15  vertical top porch
//  V_BOTTOM       3  vertical bottom porch
//  V_SYNC         4  vsync width
//  LOCK_LINES     4  consecutive good lines needed before frame tracking
//  LOCK_FRAMES    2  consecutive good frames needed for lock
//  Derived: H_TOTAL=sum of H_* (1184), V_TOTAL=sum of V_* (790),
//  H_SYNC_START=H_DISPLAY+H_FRONT (1072), V_SYNC_START=V_DISPLAY+V_BOTTOM (771)
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   synchronous reset, active-high
//  hsync_in     in   1   incoming hsync, active-high
//  vsync_in     in   1   incoming vsync, active-high
//  hpos         out 11   recovered column, 0..H_TOTAL-1
//  vpos         out 10   recovered line, 0..V_TOTAL-1
//  display_on   out  1   locked && hpos<H_DISPLAY && vpos<V_DISPLAY (combinational)
//  locked       out  1   timing lock achieved
//  frame_start  out  1   1-cycle pulse: locked and hpos,vpos wrap to 0,0
//  sync_err     out  1   1-cycle pulse on any line/frame timing violation
// BEHAVIOUR
//  - hsync_in/vsync_in registered once (hs_d, vs_d); hs_rise=hsync_in&~hs_d, vs_rise likewise.
//  - hpos free-runs +1, wraps H_TOTAL-1->0; on hs_rise edge hpos<=H_SYNC_START+1.
//    Locked stream => hpos==H_SYNC_START on every hs_rise cycle.
//  - vpos +1 on hpos wrap, wraps V_TOTAL-1->0; on vs_rise vpos<=V_SYNC_START (beats increment).
//  - Line error: hs_rise with hpos!=H_SYNC_START, or hpos==H_SYNC_START with hsync_in low.
//    Frame error: vs_rise with vpos!=V_SYNC_START.
//    Both checked only in HTRACK/VTRACK/LOCKED.
//  - FSM (reset -> SEARCH):
//    SEARCH: first hs_rise -> HTRACK, line_cnt=0.
//    HTRACK: each error-free hs_rise line_cnt++; at LOCK_LINES wait for vs_rise -> VTRACK, frm_cnt=0.
//    VTRACK: error-free vs_rise frm_cnt++; frm_cnt==LOCK_FRAMES -> LOCKED.
//    LOCKED: locked=1; stays until error.
//    Any error in HTRACK/VTRACK/LOCKED: sync_err=1 next cycle, state->SEARCH, counters cleared,
//    locked=0 next cycle; the offending edge still realigns hpos/vpos.
//  - Simultaneous hs_rise and vs_rise: both processed same cycle; line error takes priority for FSM.
//  - locked, frame_start, sync_err registered; display_on forced 0 when !locked.
//  - Reset values: hpos=0, vpos=0, locked=0, frame_start=0, sync_err=0, hs_d=vs_d=0,
//    state=SEARCH. Reset mid-frame drops lock immediately.
// CONFIGURATION
//  VGA_SYNC_DEC_MEASURE_EN defined: adds outputs h_meas[11:0] (clks between last two
//  hs_rise, saturates 4095) and v_meas[10:0] (hpos wraps between last two vs_rise,
//  saturates 2047). Both reset to 0 and update in every state.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Drive from vga_hvsync_gen (defaults) -> hpos==1073 one cycle after first hs_rise;
//     locked=1 within 1 cycle of 3rd vs_rise; no sync_err.
//  2. Locked, one line shortened to 1183 clks -> sync_err pulse, locked 0; relock after
//     4 lines + 3 vsync rises.
//  3. Locked, hsync_in held low -> sync_err when hpos==1072; state SEARCH.
//  4. Locked, vsync rising at line 770 -> sync_err, vpos reloaded to 771.
//  5. reset pulsed mid-frame (vpos=400) -> next cycle hpos=0, vpos=0, locked=0, display_on=0.
//  6. MEASURE_EN build, default stream -> h_meas==1184, v_meas==790 after two frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers hpos/vpos from incoming positive hsync/vsync,
// checks every line/frame against the parameterised timing and reports lock.
// Ports: i_clk pixel clock; i_reset sync active-high reset;
//   i_hsync_in/i_vsync_in incoming syncs; o_hpos/o_vpos recovered position;
//   o_display_on visible area while locked; o_locked timing lock;
//   o_frame_start 1-cycle pulse at 0,0 while locked; o_sync_err 1-cycle
//   pulse on a timing violation.
// Option VGA_SYNC_DEC_MEASURE_EN adds o_h_meas (clks between the last two
//   hsync rises, sat 4095) and o_v_meas (line wraps between the last two
//   vsync rises, sat 2047).
module vga_sync_decoder #(
    parameter int H_DISPLAY   = 1024,
    parameter int H_BACK      = 80,
    parameter int H_FRONT     = 48,
    parameter int H_SYNC      = 32,
    parameter int V_DISPLAY   = 768,
    parameter int V_TOP       = 15,
    parameter int V_BOTTOM    = 3,
    parameter int V_SYNC      = 4,
    parameter int LOCK_LINES  = 4,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hsync_in,
    input  logic        i_vsync_in,
    output logic [10:0] o_hpos,
    output logic [9:0]  o_vpos,
    output logic        o_display_on,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_sync_err
`ifdef VGA_SYNC_DEC_MEASURE_EN
    ,
    output logic [11:0] o_h_meas,
    output logic [10:0] o_v_meas
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;
    localparam int V_TOTAL = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;
    localparam int LW      = $clog2(LOCK_LINES + 1);
    localparam int FW      = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] LP_H_SS   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] LP_H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_H_DISP = 11'(H_DISPLAY);
    localparam logic [9:0]  LP_V_SS   = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0]  LP_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_V_DISP = 10'(V_DISPLAY);
    localparam logic [LW-1:0] LP_LINES  = LW'(LOCK_LINES);
    localparam logic [FW-1:0] LP_FR_TOP = FW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_HTRACK,
        ST_VTRACK,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_hs_d;
    logic            r_vs_d;
    logic [10:0]     r_hpos;
    logic [9:0]      r_vpos;
    logic [LW-1:0]   r_line_cnt;
    logic [LW-1:0]   w_line_nx;
    logic [FW-1:0]   r_frm_cnt;
    logic [FW-1:0]   w_frm_nx;
    logic            r_locked;
    logic            r_frame_start;
    logic            r_sync_err;

    logic            w_hs_rise;
    logic            w_vs_rise;
    logic            w_line_err;
    logic            w_frame_err;
    logic            w_err;
    logic            w_hwrap;
    logic [10:0]     w_hpos_nx;
    logic [9:0]      w_vpos_nx;

    assign w_hs_rise = i_hsync_in & ~r_hs_d;
    assign w_vs_rise = i_vsync_in & ~r_vs_d;

    // Late rise, early rise, or missing hsync at the expected column.
    assign w_line_err = (w_hs_rise && (r_hpos != LP_H_SS))
                     || ((r_hpos == LP_H_SS) && !i_hsync_in);
    assign w_frame_err = w_vs_rise && (r_vpos != LP_V_SS);
    assign w_err = (r_state != ST_SEARCH) && (w_line_err || w_frame_err);

    // A realigning hsync edge replaces the natural end-of-line wrap.
    assign w_hwrap = !w_hs_rise && (r_hpos == LP_H_LAST);

    always_comb begin
        w_hpos_nx = r_hpos + 11'd1;
        if (w_hs_rise) begin
            w_hpos_nx = LP_H_SS + 11'd1;
        end else if (w_hwrap) begin
            w_hpos_nx = '0;
        end
    end

    always_comb begin
        w_vpos_nx = r_vpos;
        if (w_vs_rise) begin
            w_vpos_nx = LP_V_SS;
        end else if (w_hwrap) begin
            w_vpos_nx = (r_vpos == LP_V_LAST) ? '0 : r_vpos + 10'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_line_nx  = r_line_cnt;
        w_frm_nx   = r_frm_cnt;
        if (w_err) begin
            w_state_nx = ST_SEARCH;
            w_line_nx  = '0;
            w_frm_nx   = '0;
        end else begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_hs_rise) begin
                        w_state_nx = ST_HTRACK;
                        w_line_nx  = '0;
                    end
                end
                ST_HTRACK: begin
                    if (r_line_cnt == LP_LINES) begin
                        if (w_vs_rise) begin
                            w_state_nx = ST_VTRACK;
                            w_frm_nx   = '0;
                        end
                    end else if (w_hs_rise) begin
                        w_line_nx = r_line_cnt + LW'(1);
                    end
                end
                ST_VTRACK: begin
                    if (w_vs_rise) begin
                        if (r_frm_cnt == LP_FR_TOP) begin
                            w_state_nx = ST_LOCKED;
                        end else begin
                            w_frm_nx = r_frm_cnt + FW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    w_state_nx = ST_LOCKED;
                end
                default: begin
                    w_state_nx = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_SEARCH;
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_line_cnt    <= '0;
            r_frm_cnt     <= '0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_hs_d        <= i_hsync_in;
            r_vs_d        <= i_vsync_in;
            r_hpos        <= w_hpos_nx;
            r_vpos        <= w_vpos_nx;
            r_line_cnt    <= w_line_nx;
            r_frm_cnt     <= w_frm_nx;
            r_locked      <= (w_state_nx == ST_LOCKED);
            r_frame_start <= r_locked && (w_hpos_nx == '0)
                             && (w_vpos_nx == '0);
            r_sync_err    <= w_err;
        end
    end

`ifdef VGA_SYNC_DEC_MEASURE_EN
    logic [11:0] r_hcnt;
    logic [11:0] r_h_meas;
    logic [11:0] w_hcnt_inc;
    logic [10:0] r_vcnt;
    logic [10:0] r_v_meas;
    logic [10:0] w_vcnt_inc;

    // Counts include the current cycle/wrap so a nominal stream
    // measures exactly H_TOTAL and V_TOTAL.
    assign w_hcnt_inc = (r_hcnt == '1) ? r_hcnt : r_hcnt + 12'd1;
    assign w_vcnt_inc = (w_hwrap && (r_vcnt != '1))
                      ? r_vcnt + 11'd1 : r_vcnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt   <= '0;
            r_h_meas <= '0;
            r_vcnt   <= '0;
            r_v_meas <= '0;
        end else begin
            if (w_hs_rise) begin
                r_h_meas <= w_hcnt_inc;
                r_hcnt   <= '0;
            end else begin
                r_hcnt <= w_hcnt_inc;
            end
            if (w_vs_rise) begin
                r_v_meas <= w_vcnt_inc;
                r_vcnt   <= '0;
            end else begin
                r_vcnt <= w_vcnt_inc;
            end
        end
    end

    assign o_h_meas = r_h_meas;
    assign o_v_meas = r_v_meas;
`endif

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_locked      = r_locked;
    assign o_frame_start = r_frame_start;
    assign o_sync_err    = r_sync_err;
    assign o_display_on  = r_locked && (r_hpos < LP_H_DISP)
                           && (r_vpos < LP_V_DISP);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: small timing, a perturbable sync source and
// an abstract per-cycle reference model of the recovered timing and lock.
module tb_vga_sync_decoder;

    localparam int HD = 16, HB = 4, HF = 3, HSW = 2;
    localparam int VD = 8, VTP = 3, VB = 2, VSW = 2;
    localparam int LL = 4, LF = 2;
    localparam int HT  = HD + HB + HF + HSW;
    localparam int VT  = VD + VTP + VB + VSW;
    localparam int HSS = HD + HF;
    localparam int VSS = VD + VB;
    localparam int FR  = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
`ifdef VGA_SYNC_DEC_MEASURE_EN
    logic [11:0] h_meas;
    logic [10:0] v_meas;
`endif

    vga_sync_decoder #(
        .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HSW),
        .V_DISPLAY(VD), .V_TOP(VTP), .V_BOTTOM(VB), .V_SYNC(VSW),
        .LOCK_LINES(LL), .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_hsync_in(hsync_in),
        .i_vsync_in(vsync_in),
        .o_hpos(hpos),
        .o_vpos(vpos),
        .o_display_on(display_on),
        .o_locked(locked),
        .o_frame_start(frame_start),
        .o_sync_err(sync_err)
`ifdef VGA_SYNC_DEC_MEASURE_EN
        ,
        .o_h_meas(h_meas),
        .o_v_meas(v_meas)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Sync source position and perturbation knobs.
    int g_h = 0;
    int g_v = 0;
    bit kill_hs = 0;
    int n_vrise = 0;

    // Reference model state.
    bit m_hsd, m_vsd, m_lock, m_fs, m_err, m_trk;
    int m_h, m_v, m_lines, m_frames;

    logic [24:0] obs;
    assign obs = {hpos, vpos, locked, display_on, frame_start, sync_err};

    function automatic logic [24:0] exp_vec();
        logic d;
        d = m_lock && (m_h < HD) && (m_v < VD);
        return {11'(m_h), 10'(m_v), m_lock, d, m_fs, m_err};
    endfunction

    task automatic drive_src();
        logic pv;
        pv = vsync_in;
        hsync_in = !kill_hs && (g_h >= HSS) && (g_h < HSS + HSW);
        vsync_in = (g_v >= VSS) && (g_v < VSS + VSW);
        if (vsync_in && !pv) n_vrise++;
    endtask

    task automatic src_adv();
        g_h++;
        if (g_h >= HT) begin
            g_h = 0;
            g_v = (g_v + 1) % VT;
        end
    endtask

    // Abstract model: position is modular arithmetic re-anchored by
    // sync edges; lock is a count of good lines then good vsync edges.
    task automatic model_step();
        bit rh, rv, bad;
        int nh, nv;
        if (reset) begin
            m_hsd = 0; m_vsd = 0; m_h = 0; m_v = 0;
            m_lock = 0; m_fs = 0; m_err = 0; m_trk = 0;
            m_lines = 0; m_frames = 0;
            return;
        end
        rh = hsync_in && !m_hsd;
        rv = vsync_in && !m_vsd;
        bad = m_trk && ((rh && m_h != HSS) || (m_h == HSS && !hsync_in)
                        || (rv && m_v != VSS));
        nh = rh ? HSS + 1 : (m_h + 1) % HT;
        nv = m_v;
        if (!rh && nh == 0) nv = (m_v + 1) % VT;
        if (rv) nv = VSS;
        m_fs = m_lock && nh == 0 && nv == 0;
        m_err = bad;
        if (bad) begin
            m_trk = 0; m_lines = 0; m_frames = 0;
        end else if (!m_trk) begin
            if (rh) begin m_trk = 1; m_lines = 0; end
        end else if (m_frames == 0) begin
            if (m_lines >= LL) begin
                if (rv) m_frames = 1;
            end else if (rh) begin
                m_lines++;
            end
        end else if (rv && m_frames <= LF) begin
            m_frames++;
        end
        m_lock = m_trk && (m_frames > LF);
        m_h = nh; m_v = nv; m_hsd = hsync_in; m_vsd = vsync_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        src_adv();
        drive_src();
    endtask

    task automatic aligned_reset();
        reset = 1'b1;
        kill_hs = 0;
        tick();
        tick();
        g_h = 0;
        g_v = 0;
        drive_src();
        reset = 1'b0;
    endtask

    task automatic lock_up(output bit ok);
        aligned_reset();
        ok = 0;
        for (int i = 0; i < 6 * FR; i++) begin
            tick();
            if (locked) begin ok = 1; break; end
        end
    endtask

    task automatic seek(input int v, input int h);
        for (int i = 0; i < 2 * FR; i++) begin
            if (g_v == v && g_h == h) break;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        g_h = $urandom_range(0, HT - 1);
        g_v = $urandom_range(0, VT - 1);
        drive_src();
        repeat (3) tick();
        n_cmp++;
        if ({hpos, vpos} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_pos: got h=%0d v=%0d want 0 0", hpos, vpos);
        end
        n_cmp++;
        if ({locked, frame_start, sync_err, display_on} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {locked, frame_start, sync_err, display_on});
        end
    endtask

    task automatic test_acquire();
        bit first, got;
        int errs, fss, at;
        aligned_reset();
        n_vrise = 0; first = 0; got = 0; errs = 0; at = 0;
        for (int i = 0; i < 6 * FR; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL acq_cycle: got %h want %h", obs, exp_vec());
            end
            if (sync_err) errs++;
            if (!first && g_h == HSS + 1) begin
                first = 1;
                n_cmp++;
                if (hpos !== 11'(HSS + 1)) begin
                    n_bad++;
                    $display("FAIL acq_first_rise: got %0d want %0d",
                             hpos, HSS + 1);
                end
            end
            if (locked) begin got = 1; at = n_vrise; break; end
        end
        n_cmp++;
        if (!got || at != 3) begin
            n_bad++;
            $display("FAIL acq_lock: locked=%0b vrises=%0d want 1 3",
                     got, at);
        end
        fss = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL acq_run: got %h want %h", obs, exp_vec());
            end
            if (sync_err) errs++;
            if (frame_start) fss++;
        end
        n_cmp++;
        if (errs != 0 || fss != 1) begin
            n_bad++;
            $display("FAIL acq_pulses: errs=%0d fs=%0d want 0 1", errs, fss);
        end
    endtask

    task automatic test_short_line();
        bit ok;
        int errs, k;
        lock_up(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL short_prelock: locked=0 want 1");
        end
        seek($urandom_range(0, VT - 1), 2);
        k = int'($urandom_range(1, 3));
        g_h += k;
        drive_src();
        errs = 0;
        for (int i = 0; i < 2 * HT; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL short_cycle: got %h want %h", obs, exp_vec());
            end
            if (sync_err) errs++;
        end
        n_cmp++;
        if (errs != 1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL short_err: errs=%0d locked=%b want 1 0",
                     errs, locked);
        end
        ok = 0;
        for (int i = 0; i < 6 * FR; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL relock_cycle: got %h want %h",
                         obs, exp_vec());
            end
            if (locked) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL short_relock: locked=0 want 1");
        end
    endtask

    task automatic test_hsync_drop();
        bit ok;
        int errs;
        lock_up(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL drop_prelock: locked=0 want 1");
        end
        seek($urandom_range(0, VT - 1), 0);
        kill_hs = 1;
        drive_src();
        errs = 0;
        for (int i = 0; i < 2 * HT; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL drop_cycle: got %h want %h", obs, exp_vec());
            end
            if (sync_err) begin
                errs++;
                n_cmp++;
                if (hpos !== 11'(HSS + 1)) begin
                    n_bad++;
                    $display("FAIL drop_err_pos: got %0d want %0d",
                             hpos, HSS + 1);
                end
            end
        end
        kill_hs = 0;
        drive_src();
        n_cmp++;
        if (errs != 1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_err: errs=%0d locked=%b want 1 0",
                     errs, locked);
        end
    endtask

    task automatic test_early_vsync();
        bit ok;
        lock_up(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL early_prelock: locked=0 want 1");
        end
        seek(VSS - 1, 0);
        g_v = VSS;
        drive_src();
        tick();
        n_cmp++;
        if ({sync_err, locked, vpos} !== {1'b1, 1'b0, 10'(VSS)}) begin
            n_bad++;
            $display("FAIL early_vs: err=%b lock=%b v=%0d want 1 0 %0d",
                     sync_err, locked, vpos, VSS);
        end
        for (int i = 0; i < HT; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL early_cycle: got %h want %h", obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        lock_up(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rmid_prelock: locked=0 want 1");
        end
        seek($urandom_range(1, VD - 1), $urandom_range(1, HD - 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({hpos, vpos, locked, display_on} !== 23'd0) begin
            n_bad++;
            $display("FAIL rmid: h=%0d v=%0d lock=%b don=%b want 0 0 0 0",
                     hpos, vpos, locked, display_on);
        end
        for (int i = 0; i < HT; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rmid_cycle: got %h want %h", obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int mode;
        reset = 1'b1;
        tick();
        g_h = $urandom_range(0, HT - 1);
        g_v = $urandom_range(0, VT - 1);
        kill_hs = 0;
        drive_src();
        reset = 1'b0;
        mode = 0;
        for (int i = 0; i < 8 * FR; i++) begin
            if (g_h == 0) begin
                kill_hs = 0;
                mode = ($urandom_range(0, 39) == 0)
                       ? int'($urandom_range(1, 4)) : 0;
                if (mode == 2) kill_hs = 1;
                if (mode == 3) g_v = (g_v + 1) % VT;
                drive_src();
            end
            if (g_h == 2 && mode == 1) begin
                g_h += int'($urandom_range(1, 3));
                mode = 0;
                drive_src();
            end
            if (g_h == 2 && mode == 4) begin
                g_h -= int'($urandom_range(1, 2));
                mode = 0;
                drive_src();
            end
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand_cycle %0d: got %h want %h",
                         i, obs, exp_vec());
            end
        end
        kill_hs = 0;
        drive_src();
    endtask

`ifdef VGA_SYNC_DEC_MEASURE_EN
    task automatic test_measure();
        bit ok;
        lock_up(ok);
        for (int i = 0; i < 2 * FR; i++) tick();
        n_cmp++;
        if (h_meas !== 12'(HT) || v_meas !== 11'(VT)) begin
            n_bad++;
            $display("FAIL measure: h=%0d v=%0d want %0d %0d",
                     h_meas, v_meas, HT, VT);
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_acquire();
        test_short_line();
        test_hsync_drop();
        test_early_vsync();
        test_reset_mid();
        test_random();
`ifdef VGA_SYNC_DEC_MEASURE_EN
        test_measure();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
